// File: rtl/leaf_rx_depacketizer.sv
// Receive depacketizer: header address check, header strip, MAX_LEN truncation, SOP/EOP framed byte FIFO.
// Optional statistics counters (pkt_count, drop_count) are enabled by defining LEAF_RX_STATS_EN.
module leaf_rx_depacketizer #(
    parameter logic [7:0]  LEAF_ID = 8'h00,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [8:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        misroute,
    output logic        truncated
`ifdef LEAF_RX_STATS_EN
    ,
    output logic [15:0] pkt_count,
    output logic [15:0] drop_count
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DROP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic        misroute_q, misroute_d;
    logic        truncated_q, truncated_d;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [9:0]  mem_q [DEPTH];

    logic        fifo_full, fifo_empty;
    logic        push, pop, accept;
    logic        tail, addr_match, len_last;
    logic [9:0]  push_entry;
    logic [9:0]  head;

    assign tail       = in_data[8];
    assign addr_match = (in_data[7:0] == LEAF_ID);
    assign len_last   = (({1'b0, len_q} + 9'd1) == MAX_LEN_W);

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign in_ready   = (state_q != PAYLOAD) || !fifo_full;
    assign accept     = in_valid && in_ready;
    assign pop        = !fifo_empty && out_ready;
    assign push_entry = {(len_q == 8'd0), (tail || len_last), in_data[7:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        misroute_d  = misroute_q;
        truncated_d = truncated_q;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (addr_match) begin
                        if (!tail) begin
                            state_d = PAYLOAD;
                            len_d   = 8'd0;
                        end
                    end else begin
                        misroute_d = 1'b1;
                        if (!tail) begin
                            state_d = DROP;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    push  = 1'b1;
                    len_d = len_q + 8'd1;
                    if (tail) begin
                        state_d = IDLE;
                    end else if (len_last) begin
                        truncated_d = 1'b1;
                        state_d     = DROP;
                    end
                end
            end
            DROP: begin
                if (accept && tail) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            len_q       <= 8'd0;
            misroute_q  <= 1'b0;
            truncated_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            misroute_q  <= misroute_d;
            truncated_q <= truncated_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head[7:0] : 8'h00;
    assign out_eop   = out_valid ? head[8]   : 1'b0;
    assign out_sop   = out_valid ? head[9]   : 1'b0;
    assign misroute  = misroute_q;
    assign truncated = truncated_q;

`ifdef LEAF_RX_STATS_EN
    logic [15:0] pkt_count_q, drop_count_q;
    logic        matched_drop_q;
    logic        count_tail;

    // A tail closes a matched packet unless DROP was entered from a misrouted header.
    assign count_tail = accept && tail &&
                        (((state_q == IDLE) && addr_match) ||
                         (state_q == PAYLOAD) ||
                         ((state_q == DROP) && matched_drop_q));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pkt_count_q    <= 16'h0000;
            drop_count_q   <= 16'h0000;
            matched_drop_q <= 1'b0;
        end else begin
            if (count_tail && (pkt_count_q != 16'hFFFF)) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            if (accept && (state_q == IDLE) && !addr_match && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
            if (state_q == PAYLOAD) begin
                matched_drop_q <= 1'b1;
            end else if (state_q == IDLE) begin
                matched_drop_q <= 1'b0;
            end
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
`else
    // Statistics disabled: no counter state exists in this build.
`endif

endmodule

// File: tb/tb_leaf_rx_depacketizer.sv
// Bench for leaf_rx_depacketizer: two instances (MAX_LEN 16 and 4) checked every cycle against a queue-based packet model.
// Directed scenarios pin the model with literal expected byte sequences.
module tb_leaf_rx_depacketizer;

   localparam int DEPTH = 4;

   logic       CLK;
   logic       RESET;
   logic [8:0] inData   [2];
   logic       inValid  [2];
   logic       inReady  [2];
   logic [7:0] outData  [2];
   logic       outSop   [2];
   logic       outEop   [2];
   logic       outValid [2];
   logic       outReady [2];
   logic       misroute [2];
   logic       truncated[2];
`ifdef LEAF_RX_STATS_EN
   logic [15:0] pktCount [2];
   logic [15:0] dropCount[2];
`endif

   int checks = 0;
   int errors = 0;
   bit cmpEn  = 0;

   // Instance 0 allows long packets (backpressure tests); instance 1 truncates after 4 bytes.
   leaf_rx_depacketizer #(.LEAF_ID(8'h05), .DEPTH(DEPTH), .MAX_LEN(16)) dutLong (
      .CLK(CLK), .RESET(RESET),
      .in_data(inData[0]), .in_valid(inValid[0]), .in_ready(inReady[0]),
      .out_data(outData[0]), .out_sop(outSop[0]), .out_eop(outEop[0]),
      .out_valid(outValid[0]), .out_ready(outReady[0]),
      .misroute(misroute[0]), .truncated(truncated[0])
`ifdef LEAF_RX_STATS_EN
      , .pkt_count(pktCount[0]), .drop_count(dropCount[0])
`endif
   );

   leaf_rx_depacketizer #(.LEAF_ID(8'h05), .DEPTH(DEPTH), .MAX_LEN(4)) dutShort (
      .CLK(CLK), .RESET(RESET),
      .in_data(inData[1]), .in_valid(inValid[1]), .in_ready(inReady[1]),
      .out_data(outData[1]), .out_sop(outSop[1]), .out_eop(outEop[1]),
      .out_valid(outValid[1]), .out_ready(outReady[1]),
      .misroute(misroute[1]), .truncated(truncated[1])
`ifdef LEAF_RX_STATS_EN
      , .pkt_count(pktCount[1]), .drop_count(dropCount[1])
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Packet-level model: mode 0 = expecting header, 1 = forwarding payload, 2 = discarding.
   int          mMode[2];
   int          mCnt[2];
   bit          mMis[2];
   bit          mTrunc[2];
   bit          mMatchedDrop[2];
   int          mPkt[2];
   int          mDrop[2];
   logic [9:0]  mq0[$];
   logic [9:0]  mq1[$];
   logic [9:0]  outLog0[$];
   logic [9:0]  outLog1[$];

   function automatic int maxLen(input int k);
      return (k == 0) ? 16 : 4;
   endfunction

   function automatic int qSize(input int k);
      return (k == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic logic [9:0] qFront(input int k);
      return (k == 0) ? mq0[0] : mq1[0];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset(input int k);
      mMode[k] = 0;
      mCnt[k] = 0;
      mMis[k] = 0;
      mTrunc[k] = 0;
      mMatchedDrop[k] = 0;
      mPkt[k] = 0;
      mDrop[k] = 0;
      if (k == 0) mq0.delete();
      else        mq1.delete();
   endtask

   task automatic modelStep(input int k);
      int         sz;
      bit         rdy, acc, tl, last;
      logic [7:0] b;
      logic [9:0] e;
      sz  = qSize(k);
      rdy = (mMode[k] != 1) || (sz < DEPTH);
      acc = inValid[k] && rdy;
      if (sz > 0 && outReady[k]) begin
         if (k == 0) void'(mq0.pop_front());
         else        void'(mq1.pop_front());
      end
      if (acc) begin
         tl = inData[k][8];
         b  = inData[k][7:0];
         case (mMode[k])
            0: begin
               if (b == 8'h05) begin
                  if (tl) mPkt[k]++;
                  else begin
                     mMode[k] = 1;
                     mCnt[k] = 0;
                  end
               end else begin
                  mMis[k] = 1;
                  mDrop[k]++;
                  if (!tl) begin
                     mMode[k] = 2;
                     mMatchedDrop[k] = 0;
                  end
               end
            end
            1: begin
               last = (mCnt[k] + 1 == maxLen(k));
               e = {(mCnt[k] == 0) ? 1'b1 : 1'b0, (tl || last) ? 1'b1 : 1'b0, b};
               if (k == 0) mq0.push_back(e);
               else        mq1.push_back(e);
               mCnt[k]++;
               if (tl) begin
                  mMode[k] = 0;
                  mPkt[k]++;
               end else if (last) begin
                  mTrunc[k] = 1;
                  mMode[k] = 2;
                  mMatchedDrop[k] = 1;
               end
            end
            default: begin
               if (tl) begin
                  if (mMatchedDrop[k]) mPkt[k]++;
                  mMode[k] = 0;
               end
            end
         endcase
         if (mPkt[k] > 65535) mPkt[k] = 65535;
         if (mDrop[k] > 65535) mDrop[k] = 65535;
      end
   endtask

   always @(posedge CLK) begin
      for (int k = 0; k < 2; k++) begin
         if (RESET) modelReset(k);
         else       modelStep(k);
      end
   end

   // Every cycle, away from the active edge, compare both instances with the model.
   always @(negedge CLK) begin
      if (cmpEn) begin
         for (int k = 0; k < 2; k++) begin
            logic [9:0] h;
            checkOutput($sformatf("in_ready[%0d]", k), 32'(inReady[k]),
                        32'((mMode[k] != 1) || (qSize(k) < DEPTH)));
            checkOutput($sformatf("out_valid[%0d]", k), 32'(outValid[k]), 32'(qSize(k) > 0));
            if (qSize(k) > 0) begin
               h = qFront(k);
               checkOutput($sformatf("out_data[%0d]", k), 32'(outData[k]), 32'(h[7:0]));
               checkOutput($sformatf("out_eop[%0d]", k), 32'(outEop[k]), 32'(h[8]));
               checkOutput($sformatf("out_sop[%0d]", k), 32'(outSop[k]), 32'(h[9]));
            end
            checkOutput($sformatf("misroute[%0d]", k), 32'(misroute[k]), 32'(mMis[k]));
            checkOutput($sformatf("truncated[%0d]", k), 32'(truncated[k]), 32'(mTrunc[k]));
`ifdef LEAF_RX_STATS_EN
            checkOutput($sformatf("pkt_count[%0d]", k), 32'(pktCount[k]), 32'(mPkt[k]));
            checkOutput($sformatf("drop_count[%0d]", k), 32'(dropCount[k]), 32'(mDrop[k]));
`endif
            if (outValid[k] && outReady[k]) begin
               if (k == 0) outLog0.push_back({outSop[k], outEop[k], outData[k]});
               else        outLog1.push_back({outSop[k], outEop[k], outData[k]});
            end
         end
      end
   end

   task automatic applyStimulus(input int k, input logic [8:0] f);
      int waitCyc = 0;
      inData[k]  = f;
      inValid[k] = 1'b1;
      @(negedge CLK);
      while (!inReady[k] && waitCyc < 60) begin
         waitCyc++;
         @(negedge CLK);
      end
      if (waitCyc >= 60) begin
         checks++;
         errors++;
         $display("[TB] FAIL handshake_timeout[%0d]: flit 0x%0h not accepted within 60 cycles", k, f);
      end
      @(posedge CLK);
      #1;
      inValid[k] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic pulseReset();
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      RESET = 1'b1;
      for (int k = 0; k < 2; k++) begin
         inData[k]   = 9'h000;
         inValid[k]  = 1'b0;
         outReady[k] = 1'b0;
      end
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      cmpEn = 1;

      // Reset state.
      checkOutput("rst_in_ready", 32'(inReady[0]), 32'd1);
      checkOutput("rst_out_valid", 32'(outValid[0]), 32'd0);
      checkOutput("rst_out_data", 32'(outData[0]), 32'd0);
      checkOutput("rst_out_sop", 32'(outSop[0]), 32'd0);
      checkOutput("rst_out_eop", 32'(outEop[0]), 32'd0);
      checkOutput("rst_misroute", 32'(misroute[0]), 32'd0);
      checkOutput("rst_truncated", 32'(truncated[0]), 32'd0);

      // Basic packet with first-byte latency of one cycle.
      outReady[0] = 1'b1;
      applyStimulus(0, 9'h005);
      applyStimulus(0, 9'h0AA);
      checkOutput("lat_out_valid", 32'(outValid[0]), 32'd1);
      checkOutput("lat_out_data", 32'(outData[0]), 32'h0AA);
      applyStimulus(0, 9'h0BB);
      applyStimulus(0, 9'h1CC);
      idle(3);
      checkOutput("pkt1_len", 32'(outLog0.size()), 32'd3);
      checkOutput("pkt1_b0", 32'(outLog0[0]), 32'h2AA);
      checkOutput("pkt1_b1", 32'(outLog0[1]), 32'h0BB);
      checkOutput("pkt1_b2", 32'(outLog0[2]), 32'h1CC);
      checkOutput("pkt1_misroute", 32'(misroute[0]), 32'd0);

      // Misrouted packet is swallowed, then an empty packet.
      applyStimulus(0, 9'h007);
      applyStimulus(0, 9'h011);
      applyStimulus(0, 9'h122);
      checkOutput("mis_flag", 32'(misroute[0]), 32'd1);
      applyStimulus(0, 9'h105);
      idle(2);
      checkOutput("mis_no_output", 32'(outLog0.size()), 32'd3);
      checkOutput("mis_in_ready", 32'(inReady[0]), 32'd1);

      // Backpressure: FIFO fills, then drains in order.
      outReady[0] = 1'b0;
      fork
         begin
            applyStimulus(0, 9'h005);
            applyStimulus(0, 9'h010);
            applyStimulus(0, 9'h011);
            applyStimulus(0, 9'h012);
            applyStimulus(0, 9'h013);
            applyStimulus(0, 9'h014);
            applyStimulus(0, 9'h115);
         end
         begin
            repeat (10) @(posedge CLK);
            #1;
            checkOutput("bp_in_ready_low", 32'(inReady[0]), 32'd0);
            checkOutput("bp_full_no_out", 32'(outLog0.size()), 32'd3);
            outReady[0] = 1'b1;
         end
      join
      idle(8);
      checkOutput("bp_len", 32'(outLog0.size()), 32'd9);
      checkOutput("bp_b0", 32'(outLog0[3]), 32'h210);
      checkOutput("bp_b1", 32'(outLog0[4]), 32'h011);
      checkOutput("bp_b3", 32'(outLog0[6]), 32'h013);
      checkOutput("bp_b4", 32'(outLog0[7]), 32'h014);
      checkOutput("bp_b5", 32'(outLog0[8]), 32'h115);

      // Reset in the middle of a buffered packet.
      outReady[0] = 1'b0;
      applyStimulus(0, 9'h005);
      applyStimulus(0, 9'h021);
      applyStimulus(0, 9'h022);
      checkOutput("mid_buffered", 32'(outValid[0]), 32'd1);
      pulseReset();
      checkOutput("mid_rst_out_valid", 32'(outValid[0]), 32'd0);
      checkOutput("mid_rst_misroute", 32'(misroute[0]), 32'd0);
      outReady[0] = 1'b1;
      applyStimulus(0, 9'h105);
      idle(3);
      checkOutput("mid_rst_no_output", 32'(outLog0.size()), 32'd9);
      checkOutput("mid_rst_in_ready", 32'(inReady[0]), 32'd1);

      // Good, empty and misrouted packets from a clean reset.
      pulseReset();
      applyStimulus(0, 9'h005);
      applyStimulus(0, 9'h1AB);
      applyStimulus(0, 9'h105);
      applyStimulus(0, 9'h009);
      applyStimulus(0, 9'h1FF);
      idle(3);
      checkOutput("stats_len", 32'(outLog0.size()), 32'd10);
      checkOutput("stats_byte", 32'(outLog0[9]), 32'h3AB);
`ifdef LEAF_RX_STATS_EN
      checkOutput("stats_pkt_count", 32'(pktCount[0]), 32'd2);
      checkOutput("stats_drop_count", 32'(dropCount[0]), 32'd1);
`endif

      // Truncation on the MAX_LEN=4 instance.
      outReady[1] = 1'b1;
      applyStimulus(1, 9'h005);
      applyStimulus(1, 9'h031);
      applyStimulus(1, 9'h032);
      applyStimulus(1, 9'h033);
      applyStimulus(1, 9'h034);
      applyStimulus(1, 9'h035);
      applyStimulus(1, 9'h136);
      idle(3);
      checkOutput("trunc_len", 32'(outLog1.size()), 32'd4);
      checkOutput("trunc_b0", 32'(outLog1[0]), 32'h231);
      checkOutput("trunc_b1", 32'(outLog1[1]), 32'h032);
      checkOutput("trunc_b2", 32'(outLog1[2]), 32'h033);
      checkOutput("trunc_b3", 32'(outLog1[3]), 32'h134);
      checkOutput("trunc_flag", 32'(truncated[1]), 32'd1);
      applyStimulus(1, 9'h005);
      applyStimulus(1, 9'h1EE);
      idle(3);
      checkOutput("trunc_next_len", 32'(outLog1.size()), 32'd5);
      checkOutput("trunc_next_byte", 32'(outLog1[4]), 32'h3EE);
      checkOutput("trunc_sticky", 32'(truncated[1]), 32'd1);

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/leaf_rx_depacketizer.md
Name: leaf_rx_depacketizer

Overview:
- Clocked receive stage directly downstream of the leaf decoder's per-port output channels. One instance per decoder output, attached after the async-to-sync boundary.
- Consumes the 9-bit flit stream, checks the header address against the leaf ID, strips the header and enforces a maximum payload length.
- Buffers the payload bytes in a small FIFO and presents them with start-of-packet/end-of-packet framing to the local endpoint.

Parameters:
- LEAF_ID, 8'h00, address this leaf accepts; compared against header flit bits [7:0].
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- MAX_LEN, 16, maximum payload flits forwarded per packet; range 1..255.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_data  input  9  flit; bit 8 = tail marker, bits [7:0] = address (header flit) or payload byte.
- in_valid  input  1  flit present.
- in_ready  output  1  flit accepted when in_valid && in_ready.
- out_data  output  8  payload byte.
- out_sop  output  1  first byte of a packet.
- out_eop  output  1  last byte of a packet.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  endpoint accepts the byte when out_valid && out_ready.
- misroute  output  1  sticky; set when a header address != LEAF_ID.
- truncated  output  1  sticky; set when a packet exceeds MAX_LEN payload flits.

Behaviour:
- Reset values: out_valid=0, out_sop=0, out_eop=0, out_data=0, misroute=0, truncated=0. in_ready=1, since the FSM is in IDLE. FIFO is empty, length counter is 0.
- FSM states:
  - IDLE: next accepted flit is a header.
    - Address == LEAF_ID and tail=0: go to PAYLOAD, counter = 0, next pushed byte gets sop=1.
    - Address == LEAF_ID and tail=1: empty packet; nothing pushed, stay in IDLE.
    - Address mismatch: set misroute. If tail=0 go to DROP, else stay in IDLE.
  - PAYLOAD: each accepted flit pushes {sop, eop, byte} and increments the counter.
    - eop = tail || (counter+1 == MAX_LEN).
    - tail=1: go to IDLE.
    - counter+1 == MAX_LEN and tail=0: set truncated, go to DROP.
  - DROP: accept and discard flits; on tail=1 go to IDLE.
- in_ready:
  - 1 in IDLE and DROP.
  - In PAYLOAD, in_ready = !fifo_full.
  - No same-cycle pass-through when full: a pop in the same cycle does not raise in_ready.
- Latency: a payload flit accepted in cycle N is visible at the outputs in cycle N+1 when the FIFO was empty. Header flits add one cycle of bubble.
- FIFO:
  - Registered pointers with one extra wrap bit.
  - Push and pop in the same cycle, non-empty and non-full: occupancy unchanged.
  - Push and pop in the same cycle when empty: not possible, since out_valid=0.
- Outputs out_data, out_sop and out_eop are driven from the FIFO head. They are held stable while out_valid && !out_ready.
- Sticky flags clear only on RESET.
- RESET mid-packet:
  - FIFO flushed and FSM returns to IDLE on that edge.
  - The next accepted flit is treated as a header, even if it belongs to an old packet's body.
- The counter is 8 bits and never wraps, because MAX_LEN ≤ 255 forces the exit.

Optional Feature:
- Macro LEAF_RX_STATS_EN.
- Defined: adds output pkt_count[15:0] and output drop_count[15:0].
  - pkt_count increments on every accepted tail flit of an address-matched packet, including empty packets.
  - drop_count increments on every misrouted header.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port exists and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- LEAF_ID=8'h05. Flits 0x005, 0x0AA, 0x0BB, 0x1CC with out_ready=1 -> bytes AA(sop=1), BB, CC(eop=1) on consecutive cycles, first byte one cycle after 0x0AA is accepted; misroute=0.
- Header 0x007, then 0x011, 0x122 -> nothing output, misroute=1, in_ready stays 1 throughout. Next header 0x105 is accepted as a new packet.
- MAX_LEN=4. Header 0x005 plus 6 payload flits, last one tailed -> 4 bytes output, 4th with eop=1, truncated=1. The remaining 2 flits are consumed and discarded; FSM returns to IDLE.
- DEPTH=4, out_ready=0, 6-flit packet -> in_ready drops after the 4th payload push. Then out_ready=1 -> bytes drain in order and input resumes, with no loss or duplication.
- RESET asserted one cycle while in PAYLOAD with 2 bytes buffered -> out_valid=0 the next cycle. Flit 0x105 is then taken as an empty-packet header with no output.
- With LEAF_RX_STATS_EN: one good packet, one empty packet, one misrouted packet -> pkt_count=2, drop_count=1.
